// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predictor: branch funct3 codes and 2-bit counter encodings.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package branch_predict_unit_pkg;

    // Branch funct3 codes (B-type)
    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    // Saturating direction counter states; bit 1 is the taken prediction
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_branch_cmp.sv
// Branch condition compare: evaluates funct3 on the two forwarded operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module branch_cmp
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            legal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // Decode funct3; the two unused encodings report illegal and never-taken
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            FNC_BEQ:  taken = eq;
            FNC_BNE:  taken = !eq;
            FNC_BLT:  taken = lt_s;
            FNC_BGE:  taken = !lt_s;
            FNC_BLTU: taken = lt_u;
            FNC_BGEU: taken = !lt_u;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters for Fetch, plus Execute branch resolution, training and stats.
// Latency: lookup and resolve are combinational (0 cycles); table/stat updates visible the next cycle.
// Backpressure: none; training is frozen simply by holding r_valid low.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    output logic [XLEN-1:0]  f_pred_targ,
    input  logic             r_valid,
    input  logic [XLEN-1:0]  r_pc,
    input  logic [XLEN-1:0]  r_imm,
    input  logic [XLEN-1:0]  r_rs1,
    input  logic [XLEN-1:0]  r_rs2,
    input  logic [2:0]       r_funct3,
    input  logic             r_pred_taken,
    input  logic [XLEN-1:0]  r_pred_targ,
    output logic             r_taken,
    output logic [XLEN-1:0]  r_targ,
    output logic             r_mispredict,
    output logic [XLEN-1:0]  r_redirect_pc,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = XLEN - IDX - 2;

    logic [ENTRIES-1:0] btb_vld;
    logic [TAG-1:0]     btb_tag  [ENTRIES];
    logic [XLEN-1:0]    btb_targ [ENTRIES];
    logic [1:0]         btb_ctr  [ENTRIES];

    logic [IDX-1:0] f_idx;
    logic [TAG-1:0] f_tag;
    logic           f_hit;
    logic [IDX-1:0] r_idx;
    logic [TAG-1:0] r_tag;
    logic           r_hit;
    logic           cmp_taken;
    logic           cmp_legal;
    logic           upd;
    logic           unused_pc_lsbs;

    // Word-aligned PCs: the two low bits carry no index or tag information
    assign unused_pc_lsbs = ^{f_pc[1:0], r_pc[1:0]};

    // Fetch lookup; reads pre-update contents, no bypass from a same-cycle train
    assign f_idx        = f_pc[IDX+1:2];
    assign f_tag        = f_pc[XLEN-1:IDX+2];
    assign f_hit        = btb_vld[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_pred_taken = f_hit && btb_ctr[f_idx][1];
    assign f_pred_targ  = f_pred_taken ? btb_targ[f_idx] : '0;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1    (r_rs1),
        .rs2    (r_rs2),
        .funct3 (r_funct3),
        .taken  (cmp_taken),
        .legal  (cmp_legal)
    );

    // Execute resolve; an illegal funct3 resolves not-taken so it mispredicts iff predicted taken
    assign r_targ        = r_pc + r_imm;
    assign r_taken       = r_valid && cmp_legal && cmp_taken;
    assign r_mispredict  = r_valid && ((r_taken != r_pred_taken) ||
                                       (r_taken && (r_pred_targ != r_targ)));
    assign r_redirect_pc = r_taken ? r_targ : r_pc + XLEN'(4);

    assign r_idx = r_pc[IDX+1:2];
    assign r_tag = r_pc[XLEN-1:IDX+2];
    assign r_hit = btb_vld[r_idx] && (btb_tag[r_idx] == r_tag);
    assign upd   = r_valid && cmp_legal;

    // BTB training: taken hits strengthen and refresh target, taken misses allocate weak-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_vld <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag[i]  <= '0;
                btb_targ[i] <= '0;
                btb_ctr[i]  <= CTR_RESET;
            end
        end else if (upd) begin
            if (r_taken) begin
                btb_targ[r_idx] <= r_targ;
                if (r_hit) begin
                    btb_ctr[r_idx] <= ctr_inc(btb_ctr[r_idx]);
                end else begin
                    btb_vld[r_idx] <= 1'b1;
                    btb_tag[r_idx] <= r_tag;
                    btb_ctr[r_idx] <= CTR_WT;
                end
            end else if (r_hit) begin
                btb_ctr[r_idx] <= ctr_dec(btb_ctr[r_idx]);
            end
        end
    end

    // Performance counters; clear beats a same-cycle increment, both wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (clr_stats) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd) begin
            stat_branches <= stat_branches + CNT_W'(1);
            if (r_mispredict) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (ENTRIES=16, CNT_W=4) with hand-computed expectations.
// Latency: checks combinational outputs #1 after driving, state #1 after the training edge.
// Backpressure: n/a.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_targ;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [2:0]  r_funct3;
    logic        r_pred_taken;
    logic [31:0] r_pred_targ;
    logic        r_taken;
    logic [31:0] r_targ;
    logic        r_mispredict;
    logic [31:0] r_redirect_pc;
    logic        clr_stats;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] exp_br = '0;
    logic [3:0] exp_mp = '0;

    branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .f_pred_targ      (f_pred_targ),
        .r_valid          (r_valid),
        .r_pc             (r_pc),
        .r_imm            (r_imm),
        .r_rs1            (r_rs1),
        .r_rs2            (r_rs2),
        .r_funct3         (r_funct3),
        .r_pred_taken     (r_pred_taken),
        .r_pred_targ      (r_pred_targ),
        .r_taken          (r_taken),
        .r_targ           (r_targ),
        .r_mispredict     (r_mispredict),
        .r_redirect_pc    (r_redirect_pc),
        .clr_stats        (clr_stats),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic e_taken, input logic [31:0] e_targ,
                        input string tag);
        f_pc = pc;
        #1;
        check_eq({tag, ".pred_taken"}, {31'd0, f_pred_taken}, {31'd0, e_taken});
        check_eq({tag, ".pred_targ"}, f_pred_targ, e_targ);
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, ".stat_br"}, {28'd0, stat_branches}, {28'd0, exp_br});
        check_eq({tag, ".stat_mp"}, {28'd0, stat_mispredicts}, {28'd0, exp_mp});
    endtask

    // Drive one resolving branch for one cycle, check resolve outputs, then the stats after the edge
    task automatic resolve(input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [2:0] f3, input logic pt, input logic [31:0] ptarg,
                           input logic e_taken, input logic e_mis, input logic legal,
                           input string tag);
        r_pc = pc; r_imm = imm; r_rs1 = rs1; r_rs2 = rs2; r_funct3 = f3;
        r_pred_taken = pt; r_pred_targ = ptarg; r_valid = 1'b1;
        #1;
        check_eq({tag, ".taken"}, {31'd0, r_taken}, {31'd0, e_taken});
        check_eq({tag, ".mispredict"}, {31'd0, r_mispredict}, {31'd0, e_mis});
        check_eq({tag, ".targ"}, r_targ, pc + imm);
        check_eq({tag, ".redirect"}, r_redirect_pc, e_taken ? pc + imm : pc + 32'd4);
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        if (legal) begin
            exp_br = exp_br + 4'd1;
            if (e_mis) exp_mp = exp_mp + 4'd1;
        end
        check_stats(tag);
    endtask

    initial begin
        rst_n = 1'b0; f_pc = 32'h100; r_valid = 1'b0; r_pc = '0; r_imm = '0;
        r_rs1 = '0; r_rs2 = '0; r_funct3 = 3'b000; r_pred_taken = 1'b0;
        r_pred_targ = '0; clr_stats = 1'b0;
        #1;
        look(32'h100, 1'b0, 32'h0, "rst");
        check_stats("rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First BEQ taken, predicted NT; same-cycle lookup sees no entry yet
        f_pc = 32'h100;
        r_pc = 32'h100; r_imm = 32'h20; r_rs1 = 5; r_rs2 = 5; r_funct3 = 3'b000;
        r_pred_taken = 1'b0; r_pred_targ = 0; r_valid = 1'b1;
        #1;
        check_eq("nobypass", {31'd0, f_pred_taken}, 32'd0);
        resolve(32'h100, 32'h20, 5, 5, 3'b000, 1'b0, 0, 1'b1, 1'b1, 1'b1, "beq0");
        look(32'h100, 1'b1, 32'h120, "alloc");

        // Counter walk: 10 -> 11 -> 11 -> 11, then NT -> 10 (still taken), NT -> 01
        for (int i = 0; i < 3; i++)
            resolve(32'h100, 32'h20, 5, 5, 3'b000, 1'b1, 32'h120, 1'b1, 1'b0, 1'b1, "beq_t");
        look(32'h100, 1'b1, 32'h120, "strong");
        resolve(32'h100, 32'h20, 5, 6, 3'b000, 1'b1, 32'h120, 1'b0, 1'b1, 1'b1, "beq_nt1");
        look(32'h100, 1'b1, 32'h120, "weak_t");
        resolve(32'h100, 32'h20, 5, 6, 3'b000, 1'b1, 32'h120, 1'b0, 1'b1, 1'b1, "beq_nt2");
        look(32'h100, 1'b0, 32'h0, "weak_nt");

        // Alias on index 0 evicts 0x100
        resolve(32'h140, 32'h40, 1, 2, 3'b001, 1'b0, 0, 1'b1, 1'b1, 1'b1, "bne_alias");
        look(32'h100, 1'b0, 32'h0, "evicted");
        look(32'h140, 1'b1, 32'h180, "alias_hit");

        // Unsigned vs signed compare of 0xFFFFFFFF against 1
        resolve(32'h200, 32'h10, 32'hFFFF_FFFF, 1, 3'b110, 1'b0, 0, 1'b0, 1'b0, 1'b1, "bltu");
        resolve(32'h200, 32'h10, 32'hFFFF_FFFF, 1, 3'b100, 1'b0, 0, 1'b1, 1'b1, 1'b1, "blt");
        resolve(32'h200, 32'h10, 32'hFFFF_FFFF, 1, 3'b111, 1'b1, 32'h210, 1'b1, 1'b0, 1'b1, "bgeu");

        // Target mismatch with correct direction
        resolve(32'h100, 32'h20, 7, 7, 3'b000, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, "targ_mis");

        // Illegal funct3: no training, no stats, mispredict follows prediction
        resolve(32'h300, 32'h20, 7, 7, 3'b010, 1'b1, 32'h320, 1'b0, 1'b1, 1'b0, "illegal");
        look(32'h300, 1'b0, 32'h0, "illegal_noalloc");
        look(32'h100, 1'b1, 32'h120, "realloc");

        // Clear, then 17 resolves on a 4-bit counter wrap to 1
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        exp_br = '0; exp_mp = '0;
        check_stats("clr");
        for (int i = 0; i < 17; i++)
            resolve(32'h400, 32'h8, 3, 3, 3'b001, 1'b0, 0, 1'b0, 1'b0, 1'b1, "wrap_loop");
        check_eq("wrap17", {28'd0, stat_branches}, 32'd1);

        // Clear wins over a same-cycle mispredicting resolve
        clr_stats = 1'b1;
        exp_br = '0; exp_mp = '0;
        resolve(32'h500, 32'h8, 3, 4, 3'b100, 1'b0, 0, 1'b1, 1'b1, 1'b0, "clr_wins");
        clr_stats = 1'b0;

        // Asynchronous reset mid-sequence clears tables and stats at once
        resolve(32'h100, 32'h20, 9, 9, 3'b000, 1'b1, 32'h120, 1'b1, 1'b0, 1'b1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_br = '0; exp_mp = '0;
        check_stats("mid_rst");
        look(32'h100, 1'b0, 32'h0, "mid_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First edge after reset trains normally
        resolve(32'h100, 32'h20, 9, 9, 3'b000, 1'b0, 0, 1'b1, 1'b1, 1'b1, "post_rst");
        look(32'h100, 1'b1, 32'h120, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
